// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the memory port arbiter.
//   arb_state_t          - arbiter FSM state encoding
//   SEL_IF / SEL_DM      - port-select codes used by the grant logic
//   STARVE_LIMIT_DEFAULT - default number of contended data grants before
//                          the fetch port is forced through
//   STARVE_CNT_W         - width of the starvation counter (limit is 1..15)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } arb_state_t;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

  localparam int STARVE_LIMIT_DEFAULT = 4;
  localparam int STARVE_CNT_W         = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// arb_starve_ctr: saturating counter that tracks how many data grants in a
// row have been given while a fetch was also waiting.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-high reset, clears the count
//   inc      - count one contended data grant
//   clr      - clear the count (fetch was granted); wins over inc
//   count    - current count, saturates at LIMIT
//   at_limit - count has reached LIMIT; fetch must win the next contention
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc,
  input  logic                    clr,
  output logic [STARVE_CNT_W-1:0] count,
  output logic                    at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT_V)) begin
      count <= count + STARVE_CNT_W'(1);
    end
  end

  assign at_limit = (count == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency memory between
// the instruction fetch (IF) stage and the data access (MEM) stage.
// Data accesses win contention, except that after STARVE_LIMIT contended
// data grants in a row the fetch is granted. Fetches killed by a branch
// flush complete on the memory side but are never acknowledged.
// Ports:
//   clk, reset            - clock (rising edge), asynchronous active-high reset
//   if_req/if_addr        - fetch request, held until its if_ack cycle
//   if_rdata/if_ack       - fetched word and one-cycle completion pulse
//   dm_read/dm_write      - data read / write request (mutually exclusive)
//   dm_addr/dm_wdata      - data address and write data
//   dm_rdata/dm_ack       - read data and one-cycle completion pulse
//   flush                 - branch taken: kill the requested or in-flight fetch
//   mem_req/mem_we/mem_addr/mem_wdata - registered memory request
//   mem_rdata/mem_ready   - memory response, sampled only while mem_req=1
//   stall_if/stall_mem    - per-stage stall while a request is outstanding
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  // data port
  input  logic          dm_read,
  input  logic          dm_write,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  // pipeline control
  input  logic          flush,
  // memory side
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  // stalls
  output logic          stall_if,
  output logic          stall_mem
);

  arb_state_t state;
  logic       discard;

  logic       dm_pending;
  logic       if_pending;
  logic       grant_valid;
  logic       grant_sel;
  logic       starve_inc;
  logic       starve_clr;
  logic       starve_at_limit;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  // The ~ack terms stop a requester that is still showing its request in
  // its own ack cycle from being granted a second time.
  assign dm_pending = (dm_read | dm_write) & ~dm_ack;
  assign if_pending = if_req & ~if_ack & ~flush;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = (dm_read | dm_write) & ~dm_ack;

  // Grant decision, only meaningful while the memory is free.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = SEL_DM;
    if (state == IDLE) begin
      if (dm_pending && !(if_pending && starve_at_limit)) begin
        grant_valid = 1'b1;
        grant_sel   = SEL_DM;
      end else if (if_pending) begin
        grant_valid = 1'b1;
        grant_sel   = SEL_IF;
      end
    end
  end

  // Only a data grant that actually made a fetch wait counts as starvation.
  assign starve_inc = grant_valid & (grant_sel == SEL_DM) & if_pending;
  assign starve_clr = grant_valid & (grant_sel == SEL_IF);

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .count    (starve_cnt),
    .at_limit (starve_at_limit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      discard   <= 1'b0;
    end else begin
      // Acks are single-cycle pulses.
      if_ack <= 1'b0;
      dm_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            mem_req <= 1'b1;
            if (grant_sel == SEL_DM) begin
              mem_we    <= dm_write;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              state     <= DM_BUSY;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
              state    <= IF_BUSY;
            end
          end
        end

        IF_BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            discard <= 1'b0;
            // A flush arriving on the completion edge kills the fetch too.
            if (!discard && !flush) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end

        DM_BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            dm_ack  <= 1'b1;
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
